key_input_ctrl: RTL and testbench

Keypad input controller for the 8-bit CPU. It synchronises and debounces a raw keypad line and queues key codes in a small FIFO. It presents the head entry to the CPU input selector port and drives the program counter's `key_event` jump request. Entries are consumed only when the CPU signals that it has read the input port.

---
 rtl/key_input_pkg.sv | 15 +
 rtl/key_debounce.sv | 84 ++++++++
 rtl/key_input_ctrl.sv | 150 +++++++++++++++
 tb/tb_key_input_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/key_input_pkg.sv
// Shared types and constants for the keypad input controller.
package key_input_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        NOTIFY = 2'd1,
        WAIT   = 2'd2
    } evt_state_t;

    localparam int VALID_BIT         = 7;
    localparam int CODE_W            = 4;
    localparam int DEF_DB_CYCLES     = 16;
    localparam int DEF_FIFO_DEPTH    = 4;

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser and debounce counter for the keypad line; emits a one-cycle
// press pulse with the sampled code. Counter present only when KEY_INPUT_DEBOUNCE_EN is defined.
module key_debounce
    import key_input_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              key_raw,
    input  logic [CODE_W-1:0] key_code,
    output logic              press,
    output logic [CODE_W-1:0] code
);

    if (DB_CYCLES < 2 || DB_CYCLES > 255) begin : g_bad_db
        $error("key_debounce: DB_CYCLES must be in 2..255");
    end

    logic [1:0]        key_sync_reg;
    logic [CODE_W-1:0] code_s1_reg;
    logic [CODE_W-1:0] code_s2_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            key_sync_reg <= '0;
            code_s1_reg  <= '0;
            code_s2_reg  <= '0;
        end else begin
            key_sync_reg <= {key_sync_reg[0], key_raw};
            code_s1_reg  <= key_code;
            code_s2_reg  <= code_s1_reg;
        end
    end

`ifdef KEY_INPUT_DEBOUNCE_EN
    localparam logic [7:0] DB_LAST = 8'(DB_CYCLES - 1);

    logic              db_state_reg;
    logic [7:0]        db_cnt_reg;
    logic              press_reg;
    logic [CODE_W-1:0] code_reg;

    // The counter tallies consecutive samples that disagree with the debounced state;
    // the DB_CYCLES-th such sample flips the state.
    always_ff @(posedge clk) begin
        if (srst) begin
            db_state_reg <= 1'b0;
            db_cnt_reg   <= '0;
            press_reg    <= 1'b0;
            code_reg     <= '0;
        end else begin
            press_reg <= 1'b0;
            if (key_sync_reg[1] == db_state_reg) begin
                db_cnt_reg <= '0;
            end else if (db_cnt_reg == DB_LAST) begin
                db_state_reg <= key_sync_reg[1];
                db_cnt_reg   <= '0;
                press_reg    <= key_sync_reg[1];
                code_reg     <= code_s2_reg;
            end else begin
                db_cnt_reg <= db_cnt_reg + 8'd1;
            end
        end
    end

    assign press = press_reg;
    assign code  = code_reg;
`else
    logic key_prev_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            key_prev_reg <= 1'b0;
        end else begin
            key_prev_reg <= key_sync_reg[1];
        end
    end

    assign press = key_sync_reg[1] & ~key_prev_reg;
    assign code  = code_s2_reg;
`endif

endmodule

// File: rtl/key_input_ctrl.sv
// Keypad input controller: debounced key codes queued in a FIFO, head presented to the CPU
// input port, one key_event per entry. Debounce enabled by defining KEY_INPUT_DEBOUNCE_EN.
module key_input_ctrl
    import key_input_pkg::*;
#(
    parameter int DB_CYCLES  = DEF_DB_CYCLES,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic       CK,
    input  logic       RST,
    input  logic       KEY_RAW,
    input  logic [3:0] KEY_CODE,
    input  logic       RD,
    output logic [7:0] IN_DATA,
    output logic       key_event,
    output logic       EMPTY,
    output logic       FULL,
    output logic       OVF
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (1 << PW) != FIFO_DEPTH) begin : g_bad_depth
        $error("key_input_ctrl: FIFO_DEPTH must be a power of two in 2..16");
    end

    logic              push;
    logic [CODE_W-1:0] push_code;

    key_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_debounce (
        .clk      (CK),
        .srst     (RST),
        .key_raw  (KEY_RAW),
        .key_code (KEY_CODE),
        .press    (push),
        .code     (push_code)
    );

    logic [CODE_W-1:0] mem [FIFO_DEPTH];
    logic [CODE_W-1:0] mem_rd_reg;
    logic [PW-1:0]     wr_ptr_reg;
    logic [PW-1:0]     rd_ptr_reg;
    logic [PW-1:0]     rd_ptr_next;
    logic [CW-1:0]     count_reg;
    logic [CW-1:0]     count_next;
    logic              empty_reg;
    logic              full_reg;
    logic              ovf_reg;
    logic              bypass_reg;
    logic [CODE_W-1:0] bypass_code_reg;
    logic              pop;
    logic              wr_en;
    logic              drop;
    evt_state_t        state_reg;
    logic              key_event_reg;

    // A push while full is still accepted when the same edge pops.
    always_comb begin
        pop         = RD && !empty_reg;
        wr_en       = push && (!full_reg || pop);
        drop        = push && full_reg && !pop;
        rd_ptr_next = pop ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
        count_next  = count_reg;
        if (wr_en && !pop) begin
            count_next = count_reg + 1'b1;
        end else if (!wr_en && pop) begin
            count_next = count_reg - 1'b1;
        end
    end

    always_ff @(posedge CK) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= push_code;
        end
        mem_rd_reg <= mem[rd_ptr_next];
    end

    // The RAM read returns old data when the next head is written on the same edge,
    // which only happens when that entry becomes the sole one; forward it instead.
    always_ff @(posedge CK) begin
        if (RST) begin
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
            empty_reg       <= 1'b1;
            full_reg        <= 1'b0;
            ovf_reg         <= 1'b0;
            bypass_reg      <= 1'b0;
            bypass_code_reg <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            rd_ptr_reg      <= rd_ptr_next;
            count_reg       <= count_next;
            empty_reg       <= (count_next == '0);
            full_reg        <= (count_next == CW'(FIFO_DEPTH));
            ovf_reg         <= ovf_reg | drop;
            bypass_reg      <= wr_en && (wr_ptr_reg == rd_ptr_next);
            bypass_code_reg <= push_code;
        end
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            state_reg     <= IDLE;
            key_event_reg <= 1'b0;
        end else begin
            key_event_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (count_reg != '0 && count_next != '0) begin
                        state_reg     <= NOTIFY;
                        key_event_reg <= 1'b1;
                    end
                end
                NOTIFY, WAIT: begin
                    if (pop) begin
                        if (count_next != '0) begin
                            state_reg     <= NOTIFY;
                            key_event_reg <= 1'b1;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end else begin
                        state_reg <= WAIT;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_comb begin
        IN_DATA = '0;
        if (!empty_reg) begin
            IN_DATA[VALID_BIT]    = 1'b1;
            IN_DATA[CODE_W-1:0]   = bypass_reg ? bypass_code_reg : mem_rd_reg;
        end
    end

    assign key_event = key_event_reg;
    assign EMPTY     = empty_reg;
    assign FULL      = full_reg;
    assign OVF       = ovf_reg;

endmodule

// File: tb/tb_key_input_ctrl.sv
// Directed bench for key_input_ctrl: queue operation table plus reset, simultaneous and bounce sequences.
module tb_key_input_ctrl;

    localparam int DB = 16;
`ifdef KEY_INPUT_DEBOUNCE_EN
    localparam int LAT = DB + 3;
`else
    localparam int LAT = 3;
`endif
    localparam int HOLD = LAT + 3;

    logic       CK = 1'b0;
    logic       RST;
    logic       KEY_RAW;
    logic [3:0] KEY_CODE;
    logic       RD;
    logic [7:0] IN_DATA;
    logic       key_event;
    logic       EMPTY;
    logic       FULL;
    logic       OVF;

    key_input_ctrl #(
        .DB_CYCLES  (DB),
        .FIFO_DEPTH (4)
    ) dut (
        .CK        (CK),
        .RST       (RST),
        .KEY_RAW   (KEY_RAW),
        .KEY_CODE  (KEY_CODE),
        .RD        (RD),
        .IN_DATA   (IN_DATA),
        .key_event (key_event),
        .EMPTY     (EMPTY),
        .FULL      (FULL),
        .OVF       (OVF)
    );

    always #5 CK = ~CK;

    int n_tests = 0;
    int n_fail  = 0;
    int ev_cnt  = 0;

    always @(posedge CK) begin
        if (key_event === 1'b1) ev_cnt = ev_cnt + 1;
    end

    typedef struct {
        bit         is_pop;
        logic [3:0] code;
        logic [7:0] exp_data;
        int         exp_ev;
        bit         exp_empty;
        bit         exp_full;
        bit         exp_ovf;
    } vec_t;

    vec_t vq[$];

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
        $display("[TB] check %s: got %0h want %0h", name, act, exp);
    endtask

    task automatic press(input logic [3:0] code);
        KEY_CODE = code;
        KEY_RAW  = 1'b1;
        ticks(HOLD);
        KEY_RAW  = 1'b0;
        ticks(HOLD);
    endtask

    task automatic pop_once();
        RD = 1'b1;
        tick();
        RD = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ev0;
        RST = 1'b1; KEY_RAW = 1'b1; KEY_CODE = 4'h9; RD = 1'b0;

        // Key held through reset
        ticks(2);
        check("rst_in_data", IN_DATA, 8'h00);
        check("rst_key_event", key_event, 1'b0);
        check("rst_empty", EMPTY, 1'b1);
        check("rst_full", FULL, 1'b0);
        check("rst_ovf", OVF, 1'b0);
        RST = 1'b0;
        ticks(LAT - 1);
        check("held_not_yet", EMPTY, 1'b1);
        tick();
        check("held_in_data", IN_DATA, 8'h89);
        tick();
        check("held_event_on", key_event, 1'b1);
        tick();
        check("held_event_off", key_event, 1'b0);
        KEY_RAW = 1'b0;
        ticks(HOLD);
        pop_once();
        check("held_single_data", IN_DATA, 8'h00);
        check("held_single_event", key_event, 1'b0);
        check("held_single_empty", EMPTY, 1'b1);
        tick();

        // Queue order, empty read and overflow table
        vq.push_back('{1'b0, 4'h3, 8'h83, 1, 1'b0, 1'b0, 1'b0});
        vq.push_back('{1'b0, 4'h7, 8'h83, 0, 1'b0, 1'b0, 1'b0});
        vq.push_back('{1'b0, 4'h5, 8'h83, 0, 1'b0, 1'b0, 1'b0});
        vq.push_back('{1'b1, 4'h0, 8'h87, 1, 1'b0, 1'b0, 1'b0});
        vq.push_back('{1'b1, 4'h0, 8'h85, 1, 1'b0, 1'b0, 1'b0});
        vq.push_back('{1'b1, 4'h0, 8'h00, 0, 1'b1, 1'b0, 1'b0});
        vq.push_back('{1'b1, 4'h0, 8'h00, 0, 1'b1, 1'b0, 1'b0});
        vq.push_back('{1'b0, 4'h1, 8'h81, 1, 1'b0, 1'b0, 1'b0});
        vq.push_back('{1'b0, 4'h2, 8'h81, 0, 1'b0, 1'b0, 1'b0});
        vq.push_back('{1'b0, 4'h4, 8'h81, 0, 1'b0, 1'b0, 1'b0});
        vq.push_back('{1'b0, 4'h6, 8'h81, 0, 1'b0, 1'b1, 1'b0});
        vq.push_back('{1'b0, 4'hE, 8'h81, 0, 1'b0, 1'b1, 1'b1});
        vq.push_back('{1'b1, 4'h0, 8'h82, 1, 1'b0, 1'b0, 1'b1});
        vq.push_back('{1'b1, 4'h0, 8'h84, 1, 1'b0, 1'b0, 1'b1});
        vq.push_back('{1'b1, 4'h0, 8'h86, 1, 1'b0, 1'b0, 1'b1});
        vq.push_back('{1'b1, 4'h0, 8'h00, 0, 1'b1, 1'b0, 1'b1});

        foreach (vq[i]) begin
            if (vq[i].is_pop) begin
                pop_once();
                check($sformatf("vec%0d_event", i), key_event, vq[i].exp_ev);
            end else begin
                ev0 = ev_cnt;
                press(vq[i].code);
                check($sformatf("vec%0d_event", i), ev_cnt - ev0, vq[i].exp_ev);
            end
            check($sformatf("vec%0d_data", i), IN_DATA, vq[i].exp_data);
            check($sformatf("vec%0d_empty", i), EMPTY, vq[i].exp_empty);
            check($sformatf("vec%0d_full", i), FULL, vq[i].exp_full);
            check($sformatf("vec%0d_ovf", i), OVF, vq[i].exp_ovf);
            tick();
        end

        // Only reset clears the overflow flag
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("ovf_cleared", OVF, 1'b0);
        check("ovf_rst_empty", EMPTY, 1'b1);

        // Push and pop on the same edge while full
        press(4'hA); press(4'hB); press(4'hC); press(4'hD);
        check("sim_full_before", FULL, 1'b1);
        KEY_CODE = 4'hF;
        KEY_RAW  = 1'b1;
        ticks(LAT - 1);
        RD = 1'b1;
        tick();
        RD = 1'b0;
        check("sim_full_after", FULL, 1'b1);
        check("sim_ovf", OVF, 1'b0);
        check("sim_head", IN_DATA, 8'h8B);
        check("sim_event", key_event, 1'b1);
        tick();
        KEY_RAW = 1'b0;
        ticks(HOLD);
        check("sim_ovf_late", OVF, 1'b0);
        pop_once();
        check("sim_pop1", IN_DATA, 8'h8C);
        tick();
        pop_once();
        check("sim_pop2", IN_DATA, 8'h8D);
        tick();
        pop_once();
        check("sim_pop3", IN_DATA, 8'h8F);
        tick();
        pop_once();
        check("sim_pop4", IN_DATA, 8'h00);
        check("sim_pop4_empty", EMPTY, 1'b1);
        tick();

`ifdef KEY_INPUT_DEBOUNCE_EN
        // Bouncing line settles high: one entry only
        KEY_CODE = 4'hA;
        for (int b = 0; b < 12; b++) begin
            KEY_RAW = (b % 2 == 0);
            ticks(5);
        end
        KEY_RAW = 1'b1;
        ticks(LAT - 1);
        check("bounce_not_yet", EMPTY, 1'b1);
        tick();
        check("bounce_in_data", IN_DATA, 8'h8A);
        tick();
        check("bounce_event", key_event, 1'b1);
        KEY_RAW = 1'b0;
        ticks(HOLD);
        pop_once();
        check("bounce_single", IN_DATA, 8'h00);
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
